// File: rtl/snd_audio_pkg.sv
// Shared widths, gain scaling and saturation helper for the audio output stage.
package snd_audio_pkg;

  localparam int unsigned PCM_W      = 16;
  localparam int unsigned GAIN_UNITY = 128;
  localparam int unsigned GAIN_SHIFT = $clog2(GAIN_UNITY);

  typedef logic signed [PCM_W-1:0] pcm_t;

  localparam pcm_t PCM_MAX = 16'sh7FFF;
  localparam pcm_t PCM_MIN = 16'sh8000;

  // Clamp a wide signed value (17- or 24-bit, sign-extended to 24) into 16-bit PCM.
  function automatic pcm_t sat16(input logic signed [23:0] v);
    pcm_t res;
    if (v > 24'(PCM_MAX)) begin
      res = PCM_MAX;
    end else if (v < 24'(PCM_MIN)) begin
      res = PCM_MIN;
    end else begin
      res = pcm_t'(v[PCM_W-1:0]);
    end
    return res;
  endfunction

endpackage

// File: rtl/snd_rate_gen.sv
// Fractional divider: one-clock strb at an average rate of SAMPLE_HZ out of CLK_HZ.
module snd_rate_gen #(
  parameter int unsigned CLK_HZ    = 48000000,
  parameter int unsigned SAMPLE_HZ = 48000
) (
  input  logic clk,
  input  logic reset,
  output logic strb
);

  logic [31:0] acc;
  logic [32:0] sum;

  always_comb begin
    sum = 33'(acc) + 33'(SAMPLE_HZ);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc  <= '0;
      strb <= 1'b0;
    end else if (sum >= 33'(CLK_HZ)) begin
      acc  <= 32'(sum - 33'(CLK_HZ));
      strb <= 1'b1;
    end else begin
      acc  <= sum[31:0];
      strb <= 1'b0;
    end
  end

endmodule

// File: rtl/snd_audio_out.sv
// PSG mix -> low-pass, decimate, DC removal, gain/mute -> 16-bit PCM with valid/ready.
// Optional 1-bit sigma-delta output enabled by defining SND_SIGMA_DELTA_EN.
import snd_audio_pkg::*;

module snd_audio_out #(
  parameter int unsigned CLK_HZ    = 48000000,
  parameter int unsigned SAMPLE_HZ = 48000,
  parameter int unsigned LP_SHIFT  = 4,
  parameter int unsigned DC_SHIFT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  snd_in,
  input  logic [7:0]  gain,
  input  logic        mute,
  output logic [15:0] pcm_out,
  output logic        pcm_valid,
  input  logic        pcm_ready,
  output logic        overrun,
  input  logic        overrun_clr,
  output logic        sd_out
);

  localparam int unsigned ACC_W = PCM_W + DC_SHIFT;

  logic              strb;
  logic [15:0]       lp;
  logic signed [16:0] lp_d;
  logic [15:0]       lp_step;
  logic [ACC_W-1:0]  dc_acc;
  logic [15:0]       dc;
  logic signed [16:0] hp;
  pcm_t              s1;
  logic              s1_v;
  logic signed [23:0] prod;
  pcm_t              r;
  pcm_t              s2;
  logic              s2_v;
  logic              xfer;

  snd_rate_gen #(
    .CLK_HZ    (CLK_HZ),
    .SAMPLE_HZ (SAMPLE_HZ)
  ) u_rate (
    .clk   (clk),
    .reset (reset),
    .strb  (strb)
  );

  // Datapath arithmetic for the low-pass, high-pass and gain stages.
  always_comb begin
    lp_d    = $signed({1'b0, snd_in, 8'h00}) - $signed({1'b0, lp});
    lp_step = 16'(lp_d >>> LP_SHIFT);
    dc      = PCM_W'(dc_acc >> DC_SHIFT);
    hp      = $signed({1'b0, lp}) - $signed({1'b0, dc});
    prod    = 24'(s1) * 24'($signed({1'b0, gain}));
    r       = mute ? pcm_t'(0) : sat16(prod >>> GAIN_SHIFT);
    xfer    = pcm_valid & pcm_ready;
  end

  // lp runs every clock; stage 1 on strb, stage 2 the following cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lp     <= '0;
      dc_acc <= '0;
      s1     <= '0;
      s1_v   <= 1'b0;
      s2     <= '0;
      s2_v   <= 1'b0;
    end else begin
      lp   <= lp + lp_step;
      s1_v <= strb;
      s2_v <= s1_v;
      if (strb) begin
        s1     <= sat16(24'(hp));
        dc_acc <= dc_acc + ACC_W'(hp);
      end
      if (s1_v) begin
        s2 <= r;
      end
    end
  end

  // Output holding register; a load over an unconsumed sample flags overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcm_out   <= '0;
      pcm_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (s2_v) begin
        pcm_out   <= s2;
        pcm_valid <= 1'b1;
      end else if (xfer) begin
        pcm_valid <= 1'b0;
      end
      if (s2_v && pcm_valid && !pcm_ready) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

`ifdef SND_SIGMA_DELTA_EN
  logic [16:0] sd_e;

  // First-order modulator on offset-binary PCM; the carry is the bitstream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sd_e <= '0;
    end else begin
      sd_e <= 17'(sd_e[15:0]) + 17'(pcm_out ^ 16'h8000);
    end
  end

  assign sd_out = sd_e[16];
`else
  assign sd_out = 1'b0;
`endif

endmodule

// File: doc/snd_audio_out.md
Name: snd_audio_out

Overview:
Downstream output stage for the 8-bit unsigned PSG mix produced by the sound block.
- Runs in the DAC clock domain.
- Low-pass filters the raw mix on every clock.
- Decimates to a fixed host sample rate.
- Removes DC, applies gain and mute.
- Presents 16-bit signed PCM to the framework audio interface over a valid/ready handshake.

Parameters:
CLK_HZ, 48000000, frequency of clk in Hz
SAMPLE_HZ, 48000, output sample rate in Hz
LP_SHIFT, 4, per-clock one-pole low-pass coefficient (2^-LP_SHIFT)
DC_SHIFT, 10, per-sample DC-tracker coefficient (2^-DC_SHIFT)

Ports:
clk  in  1  DAC clock; all logic on rising edge
reset  in  1  asynchronous, active-high
snd_in  in  8  unsigned PSG mix; sampled every clk
gain  in  8  unsigned gain, 128 = unity
mute  in  1  forces output samples to zero
pcm_out  out  16  signed PCM sample
pcm_valid  out  1  pcm_out holds an unconsumed sample
pcm_ready  in  1  consumer accepts when pcm_valid & pcm_ready
overrun  out  1  sticky: a sample was dropped
overrun_clr  in  1  synchronous clear of overrun
sd_out  out  1  1-bit sigma-delta output (see Optional Feature)

Behaviour:
- Reset (async): lp, dc_acc, phase acc, pipeline regs = 0; pcm_out = 0; pcm_valid = 0; overrun = 0; sd_out = 0.
- Rate generator:
  - 32-bit acc; each clk acc += SAMPLE_HZ.
  - If the sum >= CLK_HZ, subtract CLK_HZ in the same cycle and pulse strb for 1 clk.
  - Defaults give exactly one strb per 1000 clk; first strb at clk 1000 after reset release.
- Low-pass (every clk):
  - x = {snd_in, 8'h00} (unsigned 16).
  - d = x - lp as 17-bit signed.
  - lp <= lp + (d >>> LP_SHIFT), arithmetic shift.
  - lp stays within 0..65280.
- Stage 1 (on strb):
  - dc = dc_acc >> DC_SHIFT; dc_acc is 16+DC_SHIFT bits unsigned.
  - hp = lp - dc as 17-bit signed, saturated to 16-bit signed into s1.
  - dc_acc <= dc_acc + sign-extended (lp - dc).
  - s1_v <= 1.
- Stage 2 (cycle after s1_v):
  - p = s1 * gain, 24-bit signed.
  - r = p >>> 7, saturated to -32768..32767.
  - If mute, r = 0. mute is sampled in this cycle.
  - s2_v <= 1.
- Output (cycle after s2_v):
  - pcm_out <= r; pcm_valid <= 1.
  - Latency: strb at cycle T -> pcm_valid high at T+3.
- Handshake:
  - Transfer when pcm_valid & pcm_ready; pcm_valid drops next cycle unless a new load occurs that same cycle.
  - Load while pcm_valid=1 and no transfer: pcm_out overwritten, pcm_valid stays 1, overrun <= 1.
  - Load coinciding with a transfer: no overrun.
  - overrun_clr coinciding with a new overrun event: set wins.
- Reset mid-pipeline discards in-flight samples; no spurious pcm_valid after release.

Optional Feature:
SND_SIGMA_DELTA_EN
- Defined: first-order sigma-delta on clk.
  - e is 17-bit; e <= e[15:0] + (pcm_out ^ 16'h8000).
  - sd_out = e[16], registered.
  - Tracks pcm_out regardless of handshake.
  - Output density = (pcm_out + 32768) / 65536.
- Not defined: sd_out tied 0; no sigma-delta logic.

Decomposition:
- Package snd_audio_pkg holds:
  - PCM width 16, gain unity 128, saturation limits 16'sh7FFF / 16'sh8000
  - sat16 function (17/24-bit signed -> 16 signed)
- Sub-module snd_rate_gen: fractional divider producing strb; parameters CLK_HZ, SAMPLE_HZ.

Test Plan:
- Default params, count clk between strb pulses over 10 samples -> exactly 1000 each; pcm_valid rises 3 clk after each strb.
- snd_in=0x80 constant, gain=128, pcm_ready=1 for 2 s simulated -> |pcm_out| <= 64 at end (DC removed).
- snd_in held 0x00 for settle, then step to 0xFF, gain=255 -> first post-step samples saturate to 32767, then decay monotonically toward 0.
- gain=0 or mute=1 with any snd_in -> every pcm_out == 0; mute toggled mid-stream affects the first sample whose stage 2 sees it.
- pcm_ready=0 across two loads -> overrun=1, pcm_out = second sample; overrun_clr -> 0; load coincident with transfer -> overrun stays 0.
- Async reset asserted 1 clk after strb -> pcm_valid, pcm_out, overrun = 0 immediately, and no pcm_valid until 3 clk after the next strb. With SND_SIGMA_DELTA_EN and pcm_out=16384, sd_out ones density = 0.75 ± 0.01 over 4096 clk.
